// File: rtl/lcm_gcd_feeder_pkg.sv
// Shared types and constants for the LCM/GCD feeder and its neighbours.
// FSM encoding, default operand width and watchdog limit helper.
package lcm_gcd_pkg;

  localparam int DATAWIDTH_DEF = 8;
  localparam int WD_MARGIN     = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10
  } state_t;

  function automatic int wd_limit(input int dw);
    return (1 << dw) + WD_MARGIN;
  endfunction

endpackage

// File: rtl/lcm_gcd_feeder_if.sv
// Operand stream plus core issue bus of the LCM/GCD feeder.
// Optional hang flag present with LCM_GCD_FEEDER_WATCHDOG_EN.
interface lcm_gcd_feeder_if
  import lcm_gcd_pkg::*;
#(
  parameter int DATAWIDTH  = DATAWIDTH_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int CNTWIDTH   = 8
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATAWIDTH-1:0] in_a;
  logic [DATAWIDTH-1:0] in_b;
  logic                 in_vld;
  logic                 in_rdy;
  logic [DATAWIDTH-1:0] core_a;
  logic [DATAWIDTH-1:0] core_b;
  logic                 core_en;
  logic                 core_ready;
  logic                 core_vld;
  logic                 busy;
  logic [CW-1:0]        fifo_cnt;
  logic [CNTWIDTH-1:0]  drop_cnt;
`ifdef LCM_GCD_FEEDER_WATCHDOG_EN
  logic                 hang;

  modport master (
    input  in_a, in_b, in_vld, core_ready, core_vld,
    output in_rdy, core_a, core_b, core_en,
    output busy, fifo_cnt, drop_cnt, hang
  );

  modport slave (
    output in_a, in_b, in_vld, core_ready, core_vld,
    input  in_rdy, core_a, core_b, core_en,
    input  busy, fifo_cnt, drop_cnt, hang
  );
`else
  modport master (
    input  in_a, in_b, in_vld, core_ready, core_vld,
    output in_rdy, core_a, core_b, core_en,
    output busy, fifo_cnt, drop_cnt
  );

  modport slave (
    output in_a, in_b, in_vld, core_ready, core_vld,
    input  in_rdy, core_a, core_b, core_en,
    input  busy, fifo_cnt, drop_cnt
  );
`endif

endinterface

// File: rtl/lcm_gcd_feeder_sync_fifo.sv
// Circular FIFO with wrap-bit pointers; reused by the result collector.
// Push while full is accepted when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_q, wr_d;
  logic [AW:0]      rd_q, rd_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW-1:0] == rd_q[AW-1:0]) &&
                   (wr_q[AW] != rd_q[AW]);
  assign count_o = wr_q - rd_q;
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + (AW+1)'(1);
    if (do_pop)  rd_d = rd_q + (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (do_push) begin
      mem_q[wr_q[AW-1:0]] <= din_i;
    end
  end

endmodule

// File: rtl/lcm_gcd_feeder.sv
// Buffers operand pairs and issues them one at a time to the LCM/GCD core.
// Define LCM_GCD_FEEDER_WATCHDOG_EN to add the S_WAIT watchdog and hang flag.
module lcm_gcd_feeder
  import lcm_gcd_pkg::*;
#(
  parameter int DATAWIDTH  = DATAWIDTH_DEF,
  parameter int FIFO_DEPTH = 4,
  parameter int CNTWIDTH   = 8
) (
  input  logic             clk,
  input  logic             rstn,
  lcm_gcd_feeder_if.master bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = 2 * DATAWIDTH;

  logic [CW-1:0]        cnt;
  logic [PW-1:0]        head;
  logic                 full;
  logic                 empty;
  logic                 accept;
  logic                 zero;
  logic                 push;
  logic                 pop;

  state_t               state_q, state_d;
  logic                 en_q, en_d;
  logic [DATAWIDTH-1:0] ca_q, ca_d;
  logic [DATAWIDTH-1:0] cb_q, cb_d;
  logic [CNTWIDTH-1:0]  drop_q, drop_d;

`ifdef LCM_GCD_FEEDER_WATCHDOG_EN
  localparam logic [DATAWIDTH+1:0] WD_LIM =
    (DATAWIDTH+2)'(wd_limit(DATAWIDTH));
  logic [DATAWIDTH+1:0] wd_q, wd_d;
  logic                 hang_q, hang_d;
`endif

  // Zero operands would spin the subtractive core forever.
  assign accept = bus.in_vld && bus.in_rdy;
  assign zero   = (bus.in_a == '0) || (bus.in_b == '0);
  assign push   = accept && !zero;

  sync_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .din_i   ({bus.in_a, bus.in_b}),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (cnt)
  );

  assign bus.in_rdy   = !full;
  assign bus.fifo_cnt = cnt;
  assign bus.drop_cnt = drop_q;
  assign bus.core_a   = ca_q;
  assign bus.core_b   = cb_q;
  assign bus.core_en  = en_q;
  assign bus.busy     = (state_q != S_IDLE);
`ifdef LCM_GCD_FEEDER_WATCHDOG_EN
  assign bus.hang     = hang_q;
`endif

  always_comb begin
    drop_d = drop_q;
    if (accept && zero && (drop_q != '1)) begin
      drop_d = drop_q + CNTWIDTH'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    en_d    = 1'b0;
    pop     = 1'b0;
    ca_d    = ca_q;
    cb_d    = cb_q;
`ifdef LCM_GCD_FEEDER_WATCHDOG_EN
    wd_d    = wd_q;
    hang_d  = hang_q;
`endif
    unique case (1'b1)
      (state_q == S_IDLE): begin
        if (!empty && bus.core_ready) begin
          state_d = S_ISSUE;
          en_d    = 1'b1;
          pop     = 1'b1;
          ca_d    = head[PW-1:DATAWIDTH];
          cb_d    = head[DATAWIDTH-1:0];
        end
      end
      (state_q == S_ISSUE): begin
        state_d = S_WAIT;
`ifdef LCM_GCD_FEEDER_WATCHDOG_EN
        wd_d    = '0;
`endif
      end
      (state_q == S_WAIT): begin
        if (bus.core_vld) begin
          state_d = S_IDLE;
        end
`ifdef LCM_GCD_FEEDER_WATCHDOG_EN
        else begin
          wd_d = wd_q + (DATAWIDTH+2)'(1);
          // Abandon a stuck job so queued pairs keep flowing.
          if (wd_d == WD_LIM) begin
            hang_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      en_q    <= 1'b0;
      ca_q    <= '0;
      cb_q    <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      ca_q    <= ca_d;
      cb_q    <= cb_d;
      drop_q  <= drop_d;
    end
  end

`ifdef LCM_GCD_FEEDER_WATCHDOG_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_q   <= '0;
      hang_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      hang_q <= hang_d;
    end
  end
`endif

endmodule

// File: tb/tb_lcm_gcd_feeder.sv
// Directed bench for lcm_gcd_feeder with a behavioural LCM/GCD core model.
// Watchdog scenario runs only with LCM_GCD_FEEDER_WATCHDOG_EN defined.
module tb_lcm_gcd_feeder;
  import lcm_gcd_pkg::*;

  localparam int DW   = 8;
  localparam int FD   = 4;
  localparam int CNTW = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  lcm_gcd_feeder_if #(
    .DATAWIDTH (DW), .FIFO_DEPTH (FD), .CNTWIDTH (CNTW)
  ) bus ();

  lcm_gcd_feeder #(
    .DATAWIDTH (DW), .FIFO_DEPTH (FD), .CNTWIDTH (CNTW)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int vecs = 0;
  int errs = 0;

  int   cyc      = 0;
  int   en_cnt   = 0;
  int   overlap  = 0;
  int   vld_cyc  = 0;
  int   last_gap = 0;
  int   busy_cnt = 0;
  int   core_lat = 4;
  bit   core_hang = 1'b0;
  logic [15:0] iss[$];

  // Core model: ready drops on issue, vld pulses as ready returns.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus.core_ready <= 1'b1;
      bus.core_vld   <= 1'b0;
      busy_cnt       <= 0;
    end else begin
      cyc          <= cyc + 1;
      bus.core_vld <= 1'b0;
      if (bus.core_en) begin
        en_cnt   <= en_cnt + 1;
        last_gap <= cyc - vld_cyc - 1;
        iss.push_back({bus.core_a, bus.core_b});
        if (!bus.core_ready) overlap <= overlap + 1;
        if (!core_hang) begin
          bus.core_ready <= 1'b0;
          busy_cnt       <= core_lat;
        end
      end else if (!bus.core_ready) begin
        if (busy_cnt <= 1) begin
          bus.core_vld   <= 1'b1;
          bus.core_ready <= 1'b1;
          vld_cyc        <= cyc;
        end else begin
          busy_cnt <= busy_cnt - 1;
        end
      end
    end
  end

  task automatic push(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    bus.in_a   = a;
    bus.in_b   = b;
    bus.in_vld = 1'b1;
    while (!bus.in_rdy && n < 300) begin
      @(negedge clk);
      n++;
    end
    vecs++;
    if (bus.in_rdy !== 1'b1) begin
      errs++;
      $display("FAIL push_accept a=%0d b=%0d in_rdy=%b want 1", a, b, bus.in_rdy);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_vld = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (!(bus.busy === 1'b0 && bus.fifo_cnt === 0 && bus.core_ready === 1'b1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    vecs++;
    if (bus.busy !== 1'b0) begin
      errs++;
      $display("FAIL %s_drain busy=%b want 0", tag, bus.busy);
    end
  endtask

  task automatic test_reset();
    vecs++;
    if (bus.in_rdy !== 1'b1) begin errs++; $display("FAIL rst_in_rdy got %b want 1", bus.in_rdy); end
    vecs++;
    if (bus.core_en !== 1'b0 || bus.busy !== 1'b0) begin
      errs++; $display("FAIL rst_en_busy got %b%b want 00", bus.core_en, bus.busy);
    end
    vecs++;
    if (bus.fifo_cnt !== 0 || bus.drop_cnt !== 0) begin
      errs++; $display("FAIL rst_counts got %0d/%0d want 0/0", bus.fifo_cnt, bus.drop_cnt);
    end
    vecs++;
    if (bus.core_a !== 0 || bus.core_b !== 0) begin
      errs++; $display("FAIL rst_core_ab got %0d/%0d want 0/0", bus.core_a, bus.core_b);
    end
  endtask

  task automatic test_single();
    int e0, ib, n, a, b, t, g, l;
    core_lat = 6;
    e0 = en_cnt;
    ib = iss.size();
    push(8'd12, 8'd18);
    vecs++;
    if (bus.fifo_cnt !== 1 || bus.core_en !== 1'b0) begin
      errs++; $display("FAIL single_queued cnt=%0d en=%b want 1/0", bus.fifo_cnt, bus.core_en);
    end
    @(negedge clk);
    vecs++;
    if (bus.core_en !== 1'b1 || bus.core_a !== 12 || bus.core_b !== 18) begin
      errs++;
      $display("FAIL single_issue en=%b a=%0d b=%0d want 1/12/18", bus.core_en, bus.core_a, bus.core_b);
    end
    vecs++;
    if (bus.busy !== 1'b1 || bus.fifo_cnt !== 0) begin
      errs++; $display("FAIL single_pop busy=%b cnt=%0d want 1/0", bus.busy, bus.fifo_cnt);
    end
    @(negedge clk);
    vecs++;
    if (bus.core_en !== 1'b0 || bus.busy !== 1'b1) begin
      errs++; $display("FAIL single_wait en=%b busy=%b want 0/1", bus.core_en, bus.busy);
    end
    n = 0;
    while (bus.core_vld !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    vecs++;
    if (bus.core_vld !== 1'b1 || bus.busy !== 1'b1) begin
      errs++; $display("FAIL single_vld vld=%b busy=%b want 1/1", bus.core_vld, bus.busy);
    end
    @(negedge clk);
    vecs++;
    if (bus.busy !== 1'b0) begin errs++; $display("FAIL single_done busy=%b want 0", bus.busy); end
    vecs++;
    if (en_cnt - e0 !== 1) begin errs++; $display("FAIL single_pulses got %0d want 1", en_cnt - e0); end
    a = int'(iss[ib][15:8]);
    b = int'(iss[ib][7:0]);
    l = a * b;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    g = a;
    l = l / g;
    vecs++;
    if (g !== 6 || l !== 36) begin errs++; $display("FAIL single_gcd_lcm got %0d/%0d want 6/36", g, l); end
  endtask

  task automatic test_zero_filter();
    int e0;
    e0 = en_cnt;
    push(8'd0, 8'd5);
    push(8'd7, 8'd0);
    repeat (3) @(negedge clk);
    vecs++;
    if (bus.drop_cnt !== 2) begin errs++; $display("FAIL zero_drop got %0d want 2", bus.drop_cnt); end
    vecs++;
    if (bus.fifo_cnt !== 0 || en_cnt !== e0) begin
      errs++; $display("FAIL zero_nowrite cnt=%0d pulses=%0d want 0/0", bus.fifo_cnt, en_cnt - e0);
    end
    for (int i = 0; i < 253; i++) push(8'd0, 8'd0);
    vecs++;
    if (bus.drop_cnt !== 255) begin errs++; $display("FAIL zero_reach got %0d want 255", bus.drop_cnt); end
    push(8'd0, 8'd9);
    push(8'd9, 8'd0);
    vecs++;
    if (bus.drop_cnt !== 255) begin errs++; $display("FAIL zero_saturate got %0d want 255", bus.drop_cnt); end
  endtask

  task automatic test_fill();
    logic [15:0] exp_q [6];
    int ib, ov0;
    exp_q = '{16'hFF01, 16'h0304, 16'h0506, 16'h0708, 16'h090A, 16'h0B0C};
    core_lat = 40;
    ib  = iss.size();
    ov0 = overlap;
    push(8'd255, 8'd1);
    repeat (2) @(negedge clk);
    push(8'd3, 8'd4);
    push(8'd5, 8'd6);
    push(8'd7, 8'd8);
    push(8'd9, 8'd10);
    vecs++;
    if (bus.fifo_cnt !== 4 || bus.in_rdy !== 1'b0) begin
      errs++; $display("FAIL fill_full cnt=%0d rdy=%b want 4/0", bus.fifo_cnt, bus.in_rdy);
    end
    vecs++;
    if (bus.busy !== 1'b1 || iss.size() - ib !== 1) begin
      errs++; $display("FAIL fill_stalled busy=%b issued=%0d want 1/1", bus.busy, iss.size() - ib);
    end
    push(8'd11, 8'd12);
    vecs++;
    if (bus.fifo_cnt !== 4) begin errs++; $display("FAIL fill_refill cnt=%0d want 4", bus.fifo_cnt); end
    wait_drain("fill");
    vecs++;
    if (iss.size() - ib !== 6) begin
      errs++; $display("FAIL fill_count issued=%0d want 6", iss.size() - ib);
    end
    for (int i = 0; i < 6; i++) begin
      if (ib + i < iss.size()) begin
        vecs++;
        if (iss[ib+i] !== exp_q[i]) begin
          errs++; $display("FAIL fill_order idx=%0d got %h want %h", i, iss[ib+i], exp_q[i]);
        end
      end
    end
    vecs++;
    if (overlap !== ov0) begin errs++; $display("FAIL fill_overlap got %0d want %0d", overlap, ov0); end
    vecs++;
    if (last_gap < 1 || last_gap > 2) begin
      errs++; $display("FAIL back_to_back_gap got %0d want 1..2", last_gap);
    end
  endtask

  task automatic test_reset_mid();
    int e0;
    core_lat = 100;
    push(8'd20, 8'd30);
    repeat (3) @(negedge clk);
    push(8'd21, 8'd31);
    push(8'd22, 8'd32);
    push(8'd23, 8'd33);
    vecs++;
    if (bus.fifo_cnt !== 3 || bus.busy !== 1'b1) begin
      errs++; $display("FAIL rmid_pre cnt=%0d busy=%b want 3/1", bus.fifo_cnt, bus.busy);
    end
    #2 rstn = 1'b0;
    #1;
    vecs++;
    if (bus.fifo_cnt !== 0 || bus.busy !== 1'b0 || bus.core_en !== 1'b0) begin
      errs++;
      $display("FAIL rmid_state cnt=%0d busy=%b en=%b want 0/0/0", bus.fifo_cnt, bus.busy, bus.core_en);
    end
    vecs++;
    if (bus.drop_cnt !== 0 || bus.core_a !== 0 || bus.core_b !== 0) begin
      errs++;
      $display("FAIL rmid_regs drop=%0d a=%0d b=%0d want 0/0/0", bus.drop_cnt, bus.core_a, bus.core_b);
    end
    @(negedge clk);
    rstn = 1'b1;
    e0 = en_cnt;
    vecs++;
    if (bus.in_rdy !== 1'b1) begin errs++; $display("FAIL rmid_rdy got %b want 1", bus.in_rdy); end
    repeat (20) @(negedge clk);
    vecs++;
    if (en_cnt !== e0 || bus.busy !== 1'b0) begin
      errs++; $display("FAIL rmid_stray pulses=%0d busy=%b want 0/0", en_cnt - e0, bus.busy);
    end
    core_lat = 4;
  endtask

`ifdef LCM_GCD_FEEDER_WATCHDOG_EN
  task automatic test_watchdog();
    int n = 0;
    core_hang = 1'b1;
    push(8'd40, 8'd50);
    push(8'd60, 8'd70);
    vecs++;
    if (bus.core_en !== 1'b1 || bus.core_a !== 40 || bus.hang !== 1'b0) begin
      errs++;
      $display("FAIL wd_issue en=%b a=%0d hang=%b want 1/40/0", bus.core_en, bus.core_a, bus.hang);
    end
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.hang === 1'b1) break;
      if (bus.busy === 1'b1) n++;
    end
    vecs++;
    if (n !== 260 || bus.hang !== 1'b1) begin
      errs++; $display("FAIL wd_cycles got %0d hang=%b want 260/1", n, bus.hang);
    end
    vecs++;
    if (bus.busy !== 1'b0) begin errs++; $display("FAIL wd_idle busy=%b want 0", bus.busy); end
    @(negedge clk);
    vecs++;
    if (bus.core_en !== 1'b1 || bus.core_a !== 60 || bus.core_b !== 70) begin
      errs++;
      $display("FAIL wd_next en=%b a=%0d b=%0d want 1/60/70", bus.core_en, bus.core_a, bus.core_b);
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_a   = '0;
    bus.in_b   = '0;
    bus.in_vld = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_zero_filter();
    test_fill();
    test_reset_mid();
`ifdef LCM_GCD_FEEDER_WATCHDOG_EN
    test_watchdog();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
